tt_um_priority_decoder: RTL and testbench

Companion to the 16-bit priority encoder: takes the 8-bit encoder code word (0x00–0x0F = bit index, 0xF0 = "no input active") on `ui_in` and drives the matching 16-bit one-hot pattern on `{uio_out, uo_out}`. Input is synchronised and stability-filtered, and each applied pattern is held for a minimum time, so the block can be driven straight from off-chip switches or from another die's encoder outputs. It is a standalone Tiny Tapeout user module.

---
 rtl/tt_um_priority_decoder.sv | 91 +++++++++
 tb/tb_tt_um_priority_decoder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/tt_um_priority_decoder.sv
// tt_um_priority_decoder: filtered, hold-time-limited decoder from 8-bit priority code to 16-bit one-hot.
// Define PRIO_DEC_ILLEGAL_FLAG_EN to drive 16'hFFFF for accepted illegal codes instead of ignoring them.
module tt_um_priority_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [7:0]  s1, s2, cand;
  logic [3:0]  cnt;
  logic        acc;
  logic [15:0] pat, pend;
  logic        pend_v;
  logic [7:0]  hold;
  logic [0:0]  state;
  logic [15:0] cand_pat;
  logic        legal, accept, take, apply;
  logic        unused_ok;

  assign unused_ok = ^{uio_in, ena};
  assign uo_out    = pat[7:0];
  assign uio_out   = pat[15:8];
  assign uio_oe    = 8'hFF;

  always_comb begin
`ifdef PRIO_DEC_ILLEGAL_FLAG_EN
    legal    = 1'b1;
    cand_pat = (cand[7:4] == 4'h0) ? 16'h0001 << cand[3:0] : (cand == 8'hF0) ? 16'h0000 : 16'hFFFF;
`else
    legal    = (cand[7:4] == 4'h0) || (cand == 8'hF0);
    cand_pat = (cand[7:4] == 4'h0) ? 16'h0001 << cand[3:0] : 16'h0000;
`endif
    accept = (s2 == cand) && !acc && (cnt == 4'(STABLE_CYCLES - 1));
    // a code matching what is already driven is dropped, never queued
    take   = accept && legal && (cand_pat != pat);
    apply  = (state == IDLE) && (take || pend_v);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 8'hF0;
      s2     <= 8'hF0;
      cand   <= 8'hF0;
      cnt    <= 4'd0;
      acc    <= 1'b1;
      pat    <= 16'h0000;
      pend   <= 16'h0000;
      pend_v <= 1'b0;
      hold   <= 8'd0;
      state  <= IDLE;
    end else begin
      s1 <= ui_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= 4'd0;
        acc  <= 1'b0;
      end else if (accept) begin
        acc <= 1'b1;
      end else if (!acc) begin
        cnt <= cnt + 4'd1;
      end
      // a fresh accept wins over an older pending entry
      if (apply) begin
        pat    <= take ? cand_pat : pend;
        pend_v <= 1'b0;
        hold   <= 8'(HOLD_CYCLES);
        state  <= (HOLD_CYCLES > 0) ? HOLD : IDLE;
      end else begin
        if (take) begin
          pend   <= cand_pat;
          pend_v <= 1'b1;
        end
        if (state == HOLD) begin
          hold <= hold - 8'd1;
          if (hold == 8'd1) state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// tb_tt_um_priority_decoder: directed scoreboard bench for the priority decoder at default parameters.
module tb_tt_um_priority_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h05;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [15:0] got;
  int errors = 0;
  int checks = 0;
  string tq[$];
  logic [15:0] vq[$];

  tt_um_priority_decoder dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(8'h00), .uio_out(uio_out), .uio_oe(uio_oe), .ena(1'b1)
  );

  assign got = {uio_out, uo_out};
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    tq.push_back(tag);
    vq.push_back(v);
  endtask

  task automatic pop_check();
    string tag;
    logic [15:0] e;
    tag = tq.pop_front();
    e = vq.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, e);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] v);
    push(tag, v);
    tick();
    pop_check();
  endtask

  task automatic check_oe();
    checks++;
    assert (uio_oe === 8'hFF) else begin
      errors++;
      $error("FAIL uio_oe: got %h expected ff", uio_oe);
    end
  endtask

  initial begin
    logic [15:0] ill;
`ifdef PRIO_DEC_ILLEGAL_FLAG_EN
    ill = 16'hFFFF;
`else
    ill = 16'h0004;
`endif
    // reset with 0x05 presented; output appears at edge 6 counted from the first released edge
    push("reset_out", 16'h0000);
    tick();
    tick();
    pop_check();
    check_oe();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step($sformatf("rel_early_%0d", i), 16'h0000);
    step("rel_edge6", 16'h0020);
    for (int n = 0; n < 16; n++) begin
      ui_in = 8'(n);
      push($sformatf("decode_%0d", n), 16'h0001 << n);
      repeat (20) tick();
      pop_check();
    end
    ui_in = 8'hF0;
    push("decode_none", 16'h0000);
    repeat (20) tick();
    pop_check();
    // glitch of 3 samples must be rejected
    ui_in = 8'h0C;
    push("glitch_base", 16'h1000);
    repeat (20) tick();
    pop_check();
    ui_in = 8'h03;
    for (int i = 0; i < 3; i++) step($sformatf("glitch_in_%0d", i), 16'h1000);
    ui_in = 8'h0C;
    for (int i = 0; i < 15; i++) step($sformatf("glitch_post_%0d", i), 16'h1000);
    // 0x00 applied at t, short 0x07, 0x0F accepted exactly at t+9
    ui_in = 8'h00;
    repeat (5) tick();
    ui_in = 8'h07;
    step("hold_pre_t", 16'h1000);
    step("hold_t", 16'h0001);
    step("hold_t1", 16'h0001);
    step("hold_t2", 16'h0001);
    ui_in = 8'h0F;
    for (int i = 3; i < 9; i++) step($sformatf("hold_t%0d", i), 16'h0001);
    step("hold_t9", 16'h8000);
    // 0x02 accepted mid-hold, pending until hold counter reaches 0
    ui_in = 8'h02;
    for (int i = 1; i < 9; i++) step($sformatf("pend_t%0d", i), 16'h8000);
    step("pend_t9", 16'h0004);
    ui_in = 8'h47;
    push("illegal", ill);
    repeat (20) tick();
    pop_check();
    // 0x01 applied at t, 0x0A pending, reset mid-hold
    ui_in = 8'h01;
    repeat (5) tick();
    ui_in = 8'h0A;
    step("mh_pre_t", ill);
    step("mh_t", 16'h0002);
    for (int i = 1; i < 6; i++) step($sformatf("mh_t%0d", i), 16'h0002);
    rst_n = 1'b0;
    step("mh_reset", 16'h0000);
    check_oe();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step($sformatf("mh_rel_%0d", i), 16'h0000);
    step("mh_rel_edge6", 16'h0400);
    repeat (12) tick();
    push("mh_settled", 16'h0400);
    pop_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
